fifo_buffer_15: RTL
===================

Name: fifo_buffer_15

Overview:
- 15-entry synchronous FIFO storage stage that sits directly downstream of the read/write address counters.
- Owns the ring-style write and read pointers and encodes them to 4-bit register addresses.
- Stores data words, gates the read/write enables against full/empty, and presents registered read data to the consumer.
- Replaces ad-hoc enable gating in front of the address counters with one self-checking buffer block.

Parameters:
- DATA_W, 8, width of each stored word.
- DEPTH, 15, number of entries; legal range 2..15, since addresses are 4 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_req  input  1  request to push wr_data this cycle.
- wr_data  input  DATA_W  word to store.
- rd_req  input  1  request to pop the oldest word this cycle.
- rd_data  output  DATA_W  registered popped word.
- rd_valid  output  1  rd_data holds a word popped on the previous cycle.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- count  output  4  current occupancy, 0..DEPTH.
- WriteReg  output  4  encoded write address (next slot to be written).
- ReadReg  output  4  encoded read address (oldest slot).
- overflow  output  1  one-cycle pulse when a write is refused.
- underflow  output  1  one-cycle pulse when a read is refused.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset: rst sampled high at a rising edge clears the following:
  - pointers: WriteReg=0, ReadReg=0
  - count=0, empty=1, full=0
  - rd_valid=0, rd_data=0
  - overflow=0, underflow=0
- Reset mid-operation discards all contents; storage array contents need not be cleared.
- Pointers: each is an internal DEPTH-bit one-hot ring, advanced only on an accepted access.
  - Encoded address = index of the set bit, 0..DEPTH-1.
  - Wraps DEPTH-1 -> 0.
  - One-hot invariant must hold every cycle; a pointer never reads as 0 one-hot.
- Write accept: wr_acc = wr_req & (~full | rd_acc).
  - On accept, mem[WriteReg] <= wr_data and the write pointer advances.
- Read accept: rd_acc = rd_req & ~empty.
  - No fall-through: a write into an empty FIFO is readable no earlier than the next cycle.
  - On accept, rd_data <= mem[ReadReg] and the read pointer advances.
- Read latency: rd_valid=1 in the cycle after rd_acc, otherwise 0.
  - rd_data holds its last value when rd_valid=0.
- Occupancy update:
  - count +1 on wr_acc only.
  - count -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- full and empty are decoded combinationally from registered count.
- Full with simultaneous rd_req and wr_req: both are accepted; count stays DEPTH; pointers both advance.
- Empty with simultaneous rd_req and wr_req: the write is accepted and the read is refused.
  - underflow pulses; count becomes 1.
- overflow = wr_req & ~wr_acc, registered, one-cycle pulse.
- underflow = rd_req & ~rd_acc, registered, one-cycle pulse.
- Refused requests never change pointers, count, or memory.
- Address equality when full: WriteReg==ReadReg both when full and when empty; the two cases are distinguished only by count.

Test Plan:
- Reset: assert rst for 2 cycles with wr_req=1 -> count=0, empty=1, WriteReg=0, ReadReg=0, no write accepted.
- Fill: write 0x01..0x0F on 15 consecutive cycles -> count=15, full=1, WriteReg wrapped to 0. Then a 16th write of 0xAA -> overflow pulse for 1 cycle, count stays 15.
- Drain: read 15 times -> rd_data=0x01..0x0F in order, each one cycle after its rd_req with rd_valid=1. Then an extra read -> underflow pulse, empty=1, rd_valid=0.
- Full with simultaneous push/pop: from full, assert rd_req+wr_req with 0x55 -> 0x01 popped, count stays 15, 0x55 is emerged as the 15th subsequent read.
- Empty with simultaneous push/pop: assert rd_req+wr_req with 0x33 -> underflow=1, count=1. The next read returns 0x33.
- Wrap and reset mid-operation: run 40 alternating push/pop cycles and check ReadReg cycles 0..14 repeatedly. Then assert rst while count=7 -> count=0 next cycle and a subsequent read gives underflow.

Source files
------------

// File: rtl/fifo_buffer_15.sv
// Synchronous FIFO stage of up to 15 entries with one-hot ring read/write pointers,
// registered read data and one-cycle refusal pulses for over/underflow.
module fifo_buffer_15 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [3:0]        count,
    output logic [3:0]        WriteReg,
    output logic [3:0]        ReadReg,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [3:0]       DEPTH_C   = 4'(DEPTH);
    localparam logic [DEPTH-1:0] PTR_INIT  = {{(DEPTH-1){1'b0}}, 1'b1};

    // Index of the set bit of a one-hot ring pointer.
    function automatic logic [3:0] onehot_to_index(input logic [DEPTH-1:0] onehot);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Advance a one-hot ring by one slot, wrapping DEPTH-1 back to 0.
    function automatic logic [DEPTH-1:0] ring_advance(input logic [DEPTH-1:0] onehot);
        return {onehot[DEPTH-2:0], onehot[DEPTH-1]};
    endfunction

    logic [DEPTH-1:0]  wr_ptr_r;
    logic [DEPTH-1:0]  rd_ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [3:0]        count_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              full_s;
    logic              empty_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [3:0]        wr_addr_s;
    logic [3:0]        rd_addr_s;
    logic [3:0]        count_next_s;

    // Status decode and access acceptance; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        full_s    = 1'b0;
        empty_s   = 1'b0;
        wr_acc_s  = 1'b0;
        rd_acc_s  = 1'b0;
        wr_addr_s = onehot_to_index(wr_ptr_r);
        rd_addr_s = onehot_to_index(rd_ptr_r);
        if (count_r == DEPTH_C) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (count_r == 4'd0) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
        rd_acc_s = rd_req & ~empty_s;
        wr_acc_s = wr_req & (~full_s | rd_acc_s);
    end

    // Occupancy next-state: only a lone push or a lone pop moves the count.
    always_comb begin
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + 4'd1;
            2'b01:   count_next_s = count_r - 4'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy, read-data and refusal-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_INIT;
            rd_ptr_r    <= PTR_INIT;
            count_r     <= 4'd0;
            rd_data_r   <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= ring_advance(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r  <= ring_advance(rd_ptr_r);
                rd_data_r <= mem_r[rd_addr_s];
            end else begin
                rd_ptr_r  <= rd_ptr_r;
                rd_data_r <= rd_data_r;
            end
            count_r     <= count_next_s;
            rd_valid_r  <= rd_acc_s;
            overflow_r  <= wr_req & ~wr_acc_s;
            underflow_r <= rd_req & ~rd_acc_s;
        end
    end

    // Storage array; contents survive reset because the pointers make them unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_acc_s && wr_ptr_r[i]) begin
                mem_r[i] <= wr_data;
            end else begin
                mem_r[i] <= mem_r[i];
            end
        end
    end

    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_r;
    assign WriteReg  = wr_addr_s;
    assign ReadReg   = rd_addr_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule
